rtype_exec_core: RTL

Parametrised multi-cycle execution core for MIPS-style R-type instructions: accepts one instruction word over a valid/ready handshake, reads two operands from an internal register file, performs the ALU operation selected by `funct`, writes the result back and reports ZF/OF. It sits under the CPU top level as the successor of the fixed 32-bit single-step datapath. Width and register count are now generic, instructions are handshaked, and illegal encodings are flagged.

---
 rtl/rtype_exec_pkg.sv | 55 +++++
 rtl/rtype_exec_alu.sv | 51 +++++
 rtl/rtype_exec_core.sv | 107 ++++++++++
 3 files changed

// File: rtl/rtype_exec_pkg.sv
// Shared ALU op codes, FSM state constants, funct constants and the R-type decoder.
// Defining RTYPE_EXEC_SHIFT_EN makes sll/srl/sra legal.
package rtype_exec_pkg;

  typedef enum logic [3:0] {
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DEC  = 2'd1;
  localparam logic [1:0] ST_EXE  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic    legal;
    alu_op_e op;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opc, input logic [5:0] funct);
    dec_t d;
    d.legal = (opc == 6'd0);
    d.op    = ALU_AND;
    case (funct)
      FN_ADD:  d.op = ALU_ADD;
      FN_SUB:  d.op = ALU_SUB;
      FN_AND:  d.op = ALU_AND;
      FN_OR:   d.op = ALU_OR;
      FN_XOR:  d.op = ALU_XOR;
      FN_NOR:  d.op = ALU_NOR;
      FN_SLT:  d.op = ALU_SLT;
      FN_SLTU: d.op = ALU_SLTU;
`ifdef RTYPE_EXEC_SHIFT_EN
      FN_SLL:  d.op = ALU_SLL;
      FN_SRL:  d.op = ALU_SRL;
      FN_SRA:  d.op = ALU_SRA;
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rtype_exec_alu.sv
// Combinational ALU for the R-type core: result, zero flag, signed-overflow flag.
module rtype_alu
  import rtype_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] f_o,
  output logic              zf_o,
  output logic              of_o
);

  logic [DATA_W-1:0] sum, diff;
  logic [31:0]       sh;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  // shift amount wraps at the data width
  assign sh   = 32'(shamt_i) % 32'(DATA_W);

  always_comb begin
    f_o  = '0;
    of_o = 1'b0;
    case (op_i)
      ALU_AND:  f_o = a_i & b_i;
      ALU_OR:   f_o = a_i | b_i;
      ALU_XOR:  f_o = a_i ^ b_i;
      ALU_NOR:  f_o = ~(a_i | b_i);
      ALU_ADD: begin
        f_o  = sum;
        of_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_SUB: begin
        f_o  = diff;
        of_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_SLT:  f_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: f_o = {{(DATA_W-1){1'b0}}, a_i < b_i};
      ALU_SLL:  f_o = b_i << sh;
      ALU_SRL:  f_o = b_i >> sh;
      ALU_SRA:  f_o = $signed(b_i) >>> sh;
      default:  f_o = '0;
    endcase
  end

  assign zf_o = (f_o == '0);

endmodule

// File: rtl/rtype_exec_core.sv
// Four-state (IDLE/DEC/EXE/WB) R-type execution core with inline register file.
// Shift instructions are available when RTYPE_EXEC_SHIFT_EN is defined.
module rtype_exec_core
  import rtype_exec_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int REG_N  = 32,
  localparam int AW     = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic [31:0]       inst_code,
  output logic              inst_ready,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] alu_f,
  output logic              zf,
  output logic              of,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [1:0]        state_q, state_d;
  logic [31:0]       inst_q;
  logic [DATA_W-1:0] a_q, b_q, f_q;
  logic              zf_q, of_q, ill_q;
  alu_op_e           op_q;
  logic [DATA_W-1:0] regs_q [REG_N];

  logic [AW-1:0]     rs, rt, rd;
  dec_t              dec;
  logic [DATA_W-1:0] alu_f_c;
  logic              alu_zf_c, alu_of_c;

  assign rs  = inst_q[21 +: AW];
  assign rt  = inst_q[16 +: AW];
  assign rd  = inst_q[11 +: AW];
  assign dec = decode(inst_q[31:26], inst_q[5:0]);

  rtype_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .shamt_i (inst_q[10:6]),
    .f_o     (alu_f_c),
    .zf_o    (alu_zf_c),
    .of_o    (alu_of_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (inst_valid) state_d = ST_DEC;
      ST_DEC:  state_d = ST_EXE;
      ST_EXE:  state_d = ST_WB;
      default: state_d = ST_IDLE;
    endcase
  end

  assign inst_ready = (state_q == ST_IDLE);
  assign done       = (state_q == ST_WB);
  assign illegal    = done & ill_q;
  assign wb_en      = done & ~ill_q & (rd != '0);
  assign wb_addr    = rd;
  assign wb_data    = f_q;
  assign alu_f      = f_q;
  assign zf         = zf_q;
  assign of         = of_q;
  // r0 is never written, so a plain array read already returns zero for it
  assign dbg_data   = regs_q[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      inst_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_AND;
      ill_q   <= 1'b0;
      f_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && inst_valid) inst_q <= inst_code;
      if (state_q == ST_DEC) begin
        a_q   <= regs_q[rs];
        b_q   <= regs_q[rt];
        op_q  <= dec.op;
        ill_q <= ~dec.legal;
      end
      // illegal instructions leave the held result and flags untouched
      if (state_q == ST_EXE && !ill_q) begin
        f_q  <= alu_f_c;
        zf_q <= alu_zf_c;
        of_q <= alu_of_c;
      end
      if (wb_en) regs_q[rd] <= f_q;
    end
  end

endmodule
